load_queue: RTL and testbench
=============================

LOAD_QUEUE -- requirements
Module: load_queue

Interface
REQ-001 Parameters: DEPTH, 4, number of queued loads, power of two, >=2.
REQ-002 Parameters: ADDR_W, 32, load address width.
REQ-003 Parameters: DATA_W, 32, memory data and result width.
REQ-004 Parameters: IQ_IDX_W, 4, instruction-queue index width.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rdy  in  1  global ready; low freezes the block.
REQ-008 clear_in  in  1  flush (branch mispredict).
REQ-009 alloc_valid_in  in  1  enqueue request from reservation station.
REQ-010 alloc_func3_in  in  3  load func3: [1:0] size, [2] unsigned.
REQ-011 alloc_addr_in  in  ADDR_W  effective address.
REQ-012 alloc_iq_idx_in  in  IQ_IDX_W  destination instruction-queue slot.
REQ-013 full_out  out  1  combinational, count==DEPTH.
REQ-014 count_out  out  log2(DEPTH)+1  registered occupancy.
REQ-015 mc_req_out  out  1  one-cycle memory read request pulse.
REQ-016 mc_addr_out  out  ADDR_W  request address, held until result.
REQ-017 mc_len_out  out  2  0 byte, 1 halfword, 3 word.
REQ-018 mc_result_valid_in  in  1  memory data valid, one cycle.
REQ-019 mc_data_in  in  DATA_W  memory read data, low-aligned.
REQ-020 wb_valid_out  out  1  one-cycle write-back pulse to instruction queue.
REQ-021 wb_idx_out  out  IQ_IDX_W  instruction-queue slot written.
REQ-022 wb_data_out  out  DATA_W  extended load result.

Function
REQ-023 Storage: circular FIFO of DEPTH entries {addr, len, unsigned, iq_idx}; head/tail pointers wrap modulo DEPTH.
REQ-024 Enqueue: alloc_valid_in && !full_out && !clear_in -> write at tail, tail+1; alloc while full is dropped, no state change.
REQ-025 Length: len = (func3[1:0]==2) ? 3 : func3[1:0]; func3[1:0]==3 treated as word.
REQ-026 FSM states IDLE, WAIT; exactly one memory request outstanding.
REQ-027 IDLE, count>0 -> mc_req_out=1 for one cycle with head addr/len, go WAIT; earliest issue is cycle after enqueue (no bypass).
REQ-028 WAIT, mc_result_valid_in -> next cycle wb_valid_out=1, wb_idx_out=head iq_idx, head popped, go IDLE; next issue no earlier than following cycle.
REQ-029 Extension: byte -> bits [7:0], upper bits = unsigned?0:bit7; halfword -> [15:0] likewise with bit15; word -> unchanged.
REQ-030 Same-cycle enqueue and pop: count unchanged, both pointers advance.
REQ-031 clear_in: head=tail=0, count=0, state IDLE, wb_valid_out=0 next cycle; clear has priority over alloc and result in that cycle.
REQ-032 clear_in while WAIT (or same cycle as issue): set drop_pending; the next mc_result_valid_in is discarded (no wb pulse), then drop_pending=0; no new request issued while drop_pending.
REQ-033 rdy low: no register changes; mc_req_out, wb_valid_out forced 0; inputs ignored.
REQ-034 mc_result_valid_in in IDLE without drop_pending is ignored.

Reset
REQ-035 On rst: pointers, count_out=0, state IDLE, drop_pending=0, mc_req_out=0, wb_valid_out=0, mc_addr_out=0, mc_len_out=0, wb_idx_out=0, wb_data_out=0.
REQ-036 Reset mid-operation abandons the outstanding request; a late result after reset is ignored per REQ-034.

Structure
REQ-037 Shared defines package holds Func3 width, len codes (byte/half/word), IqAddrType, True/False.
REQ-038 One combinational sub-module load_extend (data, len, unsigned -> result) instantiated once.

Verification
REQ-039 Enqueue LB unsigned=0, addr 0x100, mem returns 0x000000F0 -> wb_data 0xFFFFFFF0, wb_idx as given; LBU -> 0x000000F0.
REQ-040 Enqueue LH/LW back-to-back, data 0x12348001 -> LH result 0xFFFF8001, LW 0x12348001, write-backs in enqueue order.
REQ-041 Fill DEPTH=4 with results held off -> full_out=1, fifth alloc dropped, count_out=4; release results -> four writes, count_out=0, pointers wrapped.
REQ-042 Clear while WAIT, then result 0xDEADBEEF -> no wb pulse; subsequent new load issues and completes normally.
REQ-043 Simultaneous alloc and result at count=2 -> count_out stays 2.
REQ-044 rdy low for 3 cycles mid-WAIT -> no pulses, state held; resumes correctly when rdy high.

Source files
------------

// File: rtl/load_queue_pkg.sv
// load_queue_pkg: shared definitions for the load queue
//   FUNC3_W          load func3 field width
//   LEN_BYTE/HALF/WORD  memory access length codes
//   iq_addr_t        default instruction-queue index type
//   TRUE/FALSE       boolean constants
//   state_t          issue FSM states
//   func3_len        func3 -> length code mapping
package load_queue_pkg;
    localparam int FUNC3_W = 3;
    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd3;
    localparam int IQ_ADDR_W = 4;
    typedef logic [IQ_ADDR_W-1:0] iq_addr_t;
    localparam logic TRUE = 1'b1;
    localparam logic FALSE = 1'b0;
    typedef enum logic {IDLE, WAIT} state_t;
    // size code 2 is a word; code 3 has no defined size and is treated as a word
    function automatic logic [1:0] func3_len(input logic [FUNC3_W-1:0] f3);
        return (f3[1:0] == 2'd2) ? LEN_WORD : f3[1:0];
    endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: sign/zero extension of low-aligned memory read data
//   data_i    raw memory data, low-aligned
//   len_i     access length code (byte/half/word)
//   uns_i     1 = zero-extend, 0 = sign-extend
//   result_o  extended result
module load_extend
    import load_queue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        len_i,
    input  logic              uns_i,
    output logic [DATA_W-1:0] result_o
);
    logic sb, sh;
    assign sb = !uns_i && data_i[7];
    assign sh = !uns_i && data_i[15];
    always_comb
        result_o = (len_i == LEN_BYTE) ? {{(DATA_W-8){sb}}, data_i[7:0]} :
                   (len_i == LEN_HALF) ? {{(DATA_W-16){sh}}, data_i[15:0]} : data_i;
endmodule

// File: rtl/load_queue.sv
// load_queue: in-order load FIFO issuing one memory read at a time
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global ready, low freezes all state
//   clear_in                 flush of all queued loads
//   alloc_*_in               enqueue request (func3, address, IQ slot)
//   full_out, count_out      occupancy status
//   mc_req_out/addr/len      memory read request (pulse, held address/length)
//   mc_result_valid_in/data  memory read response
//   wb_valid/idx/data_out    write-back of the extended result
module load_queue
    import load_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int IQ_IDX_W = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                clear_in,
    input  logic                alloc_valid_in,
    input  logic [FUNC3_W-1:0]  alloc_func3_in,
    input  logic [ADDR_W-1:0]   alloc_addr_in,
    input  logic [IQ_IDX_W-1:0] alloc_iq_idx_in,
    output logic                full_out,
    output logic [CNT_W-1:0]    count_out,
    output logic                mc_req_out,
    output logic [ADDR_W-1:0]   mc_addr_out,
    output logic [1:0]          mc_len_out,
    input  logic                mc_result_valid_in,
    input  logic [DATA_W-1:0]   mc_data_in,
    output logic                wb_valid_out,
    output logic [IQ_IDX_W-1:0] wb_idx_out,
    output logic [DATA_W-1:0]   wb_data_out
);
    logic [ADDR_W-1:0]   addr_mem [DEPTH];
    logic [1:0]          len_mem  [DEPTH];
    logic                uns_mem  [DEPTH];
    logic [IQ_IDX_W-1:0] iq_mem   [DEPTH];
    state_t              state_q, state_d;
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                drop_q, drop_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          len_q, len_d;
    logic                wb_valid_q, wb_valid_d;
    logic [IQ_IDX_W-1:0] wb_idx_q, wb_idx_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                issue, done, enq;
    logic [DATA_W-1:0]   ext_data;

    assign full_out     = count_q == CNT_W'(DEPTH);
    assign count_out    = count_q;
    assign issue        = state_q == IDLE && count_q != '0 && !drop_q;
    assign done         = state_q == WAIT && mc_result_valid_in;
    assign enq          = alloc_valid_in && !full_out && !clear_in;
    assign mc_req_out   = rdy && issue;
    // the request address/length come straight from the head entry in the issue
    // cycle and are held in registers for the rest of the transaction
    assign mc_addr_out  = mc_req_out ? addr_mem[head_q] : addr_q;
    assign mc_len_out   = mc_req_out ? len_mem[head_q] : len_q;
    assign wb_valid_out = rdy && wb_valid_q;
    assign wb_idx_out   = wb_idx_q;
    assign wb_data_out  = wb_data_q;

    load_extend #(.DATA_W(DATA_W)) u_ext (
        .data_i  (mc_data_in),
        .len_i   (len_mem[head_q]),
        .uns_i   (uns_mem[head_q]),
        .result_o(ext_data)
    );

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        drop_d     = drop_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wb_valid_d = FALSE;
        wb_idx_d   = wb_idx_q;
        wb_data_d  = wb_data_q;
        if (clear_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = IDLE;
            // a request still in flight (or issued right now) will return a
            // stale result that must be swallowed; one arriving now already is
            drop_d  = issue || ((state_q == WAIT || drop_q) && !mc_result_valid_in);
        end else begin
            if (drop_q && mc_result_valid_in)
                drop_d = FALSE;
            if (issue) begin
                state_d = WAIT;
                addr_d  = addr_mem[head_q];
                len_d   = len_mem[head_q];
            end
            if (done) begin
                state_d    = IDLE;
                wb_valid_d = TRUE;
                wb_idx_d   = iq_mem[head_q];
                wb_data_d  = ext_data;
                head_d     = head_q + 1'b1;
            end
            if (enq)
                tail_d = tail_q + 1'b1;
            count_d = (enq && !done) ? count_q + 1'b1 :
                      (!enq && done) ? count_q - 1'b1 : count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            drop_q     <= FALSE;
            addr_q     <= '0;
            len_q      <= '0;
            wb_valid_q <= FALSE;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wb_valid_q <= wb_valid_d;
            wb_idx_q   <= wb_idx_d;
            wb_data_q  <= wb_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && enq) begin
            addr_mem[tail_q] <= alloc_addr_in;
            len_mem[tail_q]  <= func3_len(alloc_func3_in);
            uns_mem[tail_q]  <= alloc_func3_in[2];
            iq_mem[tail_q]   <= alloc_iq_idx_in;
        end
    end
endmodule

// File: tb/tb_load_queue.sv
// tb_load_queue: directed vector bench for load_queue
module tb_load_queue;
    logic        clk = 1'b0;
    logic        rst, rdy, clear_in, alloc_valid_in;
    logic [2:0]  alloc_func3_in;
    logic [31:0] alloc_addr_in;
    logic [3:0]  alloc_iq_idx_in;
    logic        full_out;
    logic [2:0]  count_out;
    logic        mc_req_out;
    logic [31:0] mc_addr_out;
    logic [1:0]  mc_len_out;
    logic        mc_result_valid_in;
    logic [31:0] mc_data_in;
    logic        wb_valid_out;
    logic [3:0]  wb_idx_out;
    logic [31:0] wb_data_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        av;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [3:0]  iq;
        logic        rv;
        logic [31:0] data;
        logic        req;
        logic        wbv;
        logic [3:0]  idx;
        logic [31:0] wdata;
        logic [2:0]  cnt;
        logic        full;
        logic [31:0] maddr;
        logic [1:0]  mlen;
    } vec_t;

    vec_t tbl [24];

    load_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear_in(clear_in),
        .alloc_valid_in(alloc_valid_in), .alloc_func3_in(alloc_func3_in),
        .alloc_addr_in(alloc_addr_in), .alloc_iq_idx_in(alloc_iq_idx_in),
        .full_out(full_out), .count_out(count_out),
        .mc_req_out(mc_req_out), .mc_addr_out(mc_addr_out), .mc_len_out(mc_len_out),
        .mc_result_valid_in(mc_result_valid_in), .mc_data_in(mc_data_in),
        .wb_valid_out(wb_valid_out), .wb_idx_out(wb_idx_out), .wb_data_out(wb_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rdy = 1'b1;
        clear_in = 1'b0;
        alloc_valid_in = 1'b0;
        mc_result_valid_in = 1'b0;
    endtask

    task automatic alloc(input logic [2:0] f3, input logic [31:0] a, input logic [3:0] iq);
        alloc_valid_in = 1'b1;
        alloc_func3_in = f3;
        alloc_addr_in = a;
        alloc_iq_idx_in = iq;
    endtask

    initial begin
        //            av    f3    addr          iq    rv    data            req   wbv   idx   wdata          cnt   full  maddr         mlen
        tbl[0]  = '{1'b1, 3'd0, 32'h100, 4'd5, 1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 32'h0,         3'd0, 1'b0, 32'h0,   2'd0};
        tbl[1]  = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b0, 32'h0,         1'b1, 1'b0, 4'd0, 32'h0,         3'd1, 1'b0, 32'h100, 2'd0};
        tbl[2]  = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b1, 32'h000000F0,  1'b0, 1'b0, 4'd0, 32'h0,         3'd1, 1'b0, 32'h0,   2'd0};
        tbl[3]  = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b0, 32'h0,         1'b0, 1'b1, 4'd5, 32'hFFFFFFF0,  3'd0, 1'b0, 32'h0,   2'd0};
        tbl[4]  = '{1'b1, 3'd4, 32'h104, 4'd6, 1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 32'h0,         3'd0, 1'b0, 32'h0,   2'd0};
        tbl[5]  = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b0, 32'h0,         1'b1, 1'b0, 4'd0, 32'h0,         3'd1, 1'b0, 32'h104, 2'd0};
        tbl[6]  = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b1, 32'h000000F0,  1'b0, 1'b0, 4'd0, 32'h0,         3'd1, 1'b0, 32'h0,   2'd0};
        tbl[7]  = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b0, 32'h0,         1'b0, 1'b1, 4'd6, 32'h000000F0,  3'd0, 1'b0, 32'h0,   2'd0};
        tbl[8]  = '{1'b1, 3'd1, 32'h200, 4'd1, 1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 32'h0,         3'd0, 1'b0, 32'h0,   2'd0};
        tbl[9]  = '{1'b1, 3'd2, 32'h204, 4'd2, 1'b0, 32'h0,         1'b1, 1'b0, 4'd0, 32'h0,         3'd1, 1'b0, 32'h200, 2'd1};
        tbl[10] = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b1, 32'h12348001,  1'b0, 1'b0, 4'd0, 32'h0,         3'd2, 1'b0, 32'h0,   2'd0};
        tbl[11] = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b0, 32'h0,         1'b1, 1'b1, 4'd1, 32'hFFFF8001,  3'd1, 1'b0, 32'h204, 2'd3};
        tbl[12] = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b1, 32'h12348001,  1'b0, 1'b0, 4'd0, 32'h0,         3'd1, 1'b0, 32'h0,   2'd0};
        tbl[13] = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b0, 32'h0,         1'b0, 1'b1, 4'd2, 32'h12348001,  3'd0, 1'b0, 32'h0,   2'd0};
        tbl[14] = '{1'b1, 3'd3, 32'h300, 4'd3, 1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 32'h0,         3'd0, 1'b0, 32'h0,   2'd0};
        tbl[15] = '{1'b1, 3'd2, 32'h304, 4'd4, 1'b0, 32'h0,         1'b1, 1'b0, 4'd0, 32'h0,         3'd1, 1'b0, 32'h300, 2'd3};
        tbl[16] = '{1'b1, 3'd5, 32'h308, 4'd7, 1'b1, 32'hAAAA5555,  1'b0, 1'b0, 4'd0, 32'h0,         3'd2, 1'b0, 32'h0,   2'd0};
        tbl[17] = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b0, 32'h0,         1'b1, 1'b1, 4'd3, 32'hAAAA5555,  3'd2, 1'b0, 32'h304, 2'd3};
        tbl[18] = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b1, 32'h00000011,  1'b0, 1'b0, 4'd0, 32'h0,         3'd2, 1'b0, 32'h0,   2'd0};
        tbl[19] = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b0, 32'h0,         1'b1, 1'b1, 4'd4, 32'h00000011,  3'd1, 1'b0, 32'h308, 2'd1};
        tbl[20] = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b1, 32'hFFFF9234,  1'b0, 1'b0, 4'd0, 32'h0,         3'd1, 1'b0, 32'h0,   2'd0};
        tbl[21] = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b0, 32'h0,         1'b0, 1'b1, 4'd7, 32'h00009234,  3'd0, 1'b0, 32'h0,   2'd0};
        tbl[22] = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b1, 32'h00000055,  1'b0, 1'b0, 4'd0, 32'h0,         3'd0, 1'b0, 32'h0,   2'd0};
        tbl[23] = '{1'b0, 3'd0, 32'h0,   4'd0, 1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 32'h0,         3'd0, 1'b0, 32'h0,   2'd0};

        idle_in();
        alloc_func3_in = 3'd0;
        alloc_addr_in = 32'h0;
        alloc_iq_idx_in = 4'd0;
        mc_data_in = 32'h0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_full", 32'(full_out), 32'd0);
        chk("rst_req", 32'(mc_req_out), 32'd0);
        chk("rst_wbv", 32'(wb_valid_out), 32'd0);
        chk("rst_addr", mc_addr_out, 32'd0);
        chk("rst_len", 32'(mc_len_out), 32'd0);
        chk("rst_idx", 32'(wb_idx_out), 32'd0);
        chk("rst_wdata", wb_data_out, 32'd0);
        step();

        for (int i = 0; i < 24; i++) begin
            alloc_valid_in = tbl[i].av;
            alloc_func3_in = tbl[i].f3;
            alloc_addr_in = tbl[i].addr;
            alloc_iq_idx_in = tbl[i].iq;
            mc_result_valid_in = tbl[i].rv;
            mc_data_in = tbl[i].data;
            #1;
            chk($sformatf("r%0d_req", i), 32'(mc_req_out), 32'(tbl[i].req));
            chk($sformatf("r%0d_wbv", i), 32'(wb_valid_out), 32'(tbl[i].wbv));
            chk($sformatf("r%0d_cnt", i), 32'(count_out), 32'(tbl[i].cnt));
            chk($sformatf("r%0d_full", i), 32'(full_out), 32'(tbl[i].full));
            if (tbl[i].wbv) begin
                chk($sformatf("r%0d_idx", i), 32'(wb_idx_out), 32'(tbl[i].idx));
                chk($sformatf("r%0d_wdata", i), wb_data_out, tbl[i].wdata);
            end
            if (tbl[i].req) begin
                chk($sformatf("r%0d_maddr", i), mc_addr_out, tbl[i].maddr);
                chk($sformatf("r%0d_mlen", i), 32'(mc_len_out), 32'(tbl[i].mlen));
            end
            step();
        end
        idle_in();

        // fill to DEPTH with results held off, fifth alloc dropped
        for (int i = 0; i < 5; i++) begin
            alloc(3'd2, 32'h400 + 32'(i * 4), 4'(8 + i));
            if (i == 4) begin
                #1;
                chk("fill_full", 32'(full_out), 32'd1);
                chk("fill_cnt", 32'(count_out), 32'd4);
            end
            step();
        end
        alloc_valid_in = 1'b0;
        #1;
        chk("drop_cnt", 32'(count_out), 32'd4);
        chk("drop_full", 32'(full_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            mc_result_valid_in = 1'b1;
            mc_data_in = 32'hA0000000 + 32'(i);
            step();
            mc_result_valid_in = 1'b0;
            #1;
            chk($sformatf("drain%0d_wbv", i), 32'(wb_valid_out), 32'd1);
            chk($sformatf("drain%0d_idx", i), 32'(wb_idx_out), 32'(8 + i));
            chk($sformatf("drain%0d_wdata", i), wb_data_out, 32'hA0000000 + 32'(i));
            chk($sformatf("drain%0d_cnt", i), 32'(count_out), 32'(3 - i));
            if (i < 3) begin
                chk($sformatf("drain%0d_req", i), 32'(mc_req_out), 32'd1);
                chk($sformatf("drain%0d_maddr", i), mc_addr_out, 32'h400 + 32'((i + 1) * 4));
            end
            step();
        end
        alloc(3'd0, 32'h500, 4'd13);
        step();
        alloc_valid_in = 1'b0;
        #1;
        chk("wrap_req", 32'(mc_req_out), 32'd1);
        chk("wrap_maddr", mc_addr_out, 32'h500);
        step();
        mc_result_valid_in = 1'b1;
        mc_data_in = 32'h00000080;
        step();
        mc_result_valid_in = 1'b0;
        #1;
        chk("wrap_wbv", 32'(wb_valid_out), 32'd1);
        chk("wrap_idx", 32'(wb_idx_out), 32'd13);
        chk("wrap_wdata", wb_data_out, 32'hFFFFFF80);
        step();

        // clear while a request is outstanding: its result is swallowed
        alloc(3'd2, 32'h600, 4'd9);
        step();
        alloc_valid_in = 1'b0;
        #1;
        chk("clr_req0", 32'(mc_req_out), 32'd1);
        step();
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        #1;
        chk("clr_cnt", 32'(count_out), 32'd0);
        chk("clr_wbv", 32'(wb_valid_out), 32'd0);
        alloc(3'd2, 32'h700, 4'd10);
        step();
        alloc_valid_in = 1'b0;
        #1;
        chk("clr_cnt1", 32'(count_out), 32'd1);
        chk("clr_hold_req_a", 32'(mc_req_out), 32'd0);
        step();
        chk("clr_hold_req_b", 32'(mc_req_out), 32'd0);
        mc_result_valid_in = 1'b1;
        mc_data_in = 32'hDEADBEEF;
        step();
        mc_result_valid_in = 1'b0;
        #1;
        chk("clr_stale_wbv", 32'(wb_valid_out), 32'd0);
        chk("clr_new_req", 32'(mc_req_out), 32'd1);
        chk("clr_new_maddr", mc_addr_out, 32'h700);
        step();
        mc_result_valid_in = 1'b1;
        mc_data_in = 32'h00000077;
        step();
        mc_result_valid_in = 1'b0;
        #1;
        chk("clr_new_wbv", 32'(wb_valid_out), 32'd1);
        chk("clr_new_idx", 32'(wb_idx_out), 32'd10);
        chk("clr_new_wdata", wb_data_out, 32'h00000077);
        chk("clr_new_cnt", 32'(count_out), 32'd0);
        step();

        // rdy low for three cycles mid-WAIT
        alloc(3'd1, 32'h800, 4'd11);
        step();
        alloc_valid_in = 1'b0;
        #1;
        chk("rdy_req0", 32'(mc_req_out), 32'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0;
            mc_result_valid_in = 1'b1;
            mc_data_in = 32'h00001234;
            alloc(3'd2, 32'h900, 4'd12);
            #1;
            chk($sformatf("rdy%0d_req", i), 32'(mc_req_out), 32'd0);
            chk($sformatf("rdy%0d_wbv", i), 32'(wb_valid_out), 32'd0);
            chk($sformatf("rdy%0d_maddr", i), mc_addr_out, 32'h800);
            step();
        end
        idle_in();
        #1;
        chk("rdy_cnt", 32'(count_out), 32'd1);
        chk("rdy_req", 32'(mc_req_out), 32'd0);
        chk("rdy_wbv", 32'(wb_valid_out), 32'd0);
        step();
        mc_result_valid_in = 1'b1;
        mc_data_in = 32'h00008000;
        step();
        mc_result_valid_in = 1'b0;
        #1;
        chk("rdy_res_wbv", 32'(wb_valid_out), 32'd1);
        chk("rdy_res_idx", 32'(wb_idx_out), 32'd11);
        chk("rdy_res_wdata", wb_data_out, 32'hFFFF8000);
        chk("rdy_res_cnt", 32'(count_out), 32'd0);
        step();

        // reset mid-WAIT, late result ignored
        alloc(3'd2, 32'hA00, 4'd14);
        step();
        alloc_valid_in = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mrst_cnt", 32'(count_out), 32'd0);
        chk("mrst_req", 32'(mc_req_out), 32'd0);
        mc_result_valid_in = 1'b1;
        mc_data_in = 32'h00000005;
        step();
        mc_result_valid_in = 1'b0;
        #1;
        chk("mrst_wbv", 32'(wb_valid_out), 32'd0);
        chk("mrst_cnt2", 32'(count_out), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
